// File: rtl/delay_pipe_arbiter_if.sv
// Request/pipe/response bundle for delay_pipe_arbiter.
// DELAY_PIPE_ARB_LOCK_EN adds the per-requester req_lock_i field.
interface delay_pipe_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
);
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ*WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic                     flush_i;
  logic                     pipe_valid_o;
  logic [WIDTH-1:0]         pipe_data_o;
  logic [WIDTH-1:0]         pipe_data_i;
  logic [NUM_REQ-1:0]       resp_valid_o;
  logic [WIDTH-1:0]         resp_data_o;
  logic                     busy_o;
`ifdef DELAY_PIPE_ARB_LOCK_EN
  logic [NUM_REQ-1:0]       req_lock_i;
`endif

  modport master (
    output req_valid_i, req_data_i, flush_i, pipe_data_i,
`ifdef DELAY_PIPE_ARB_LOCK_EN
    output req_lock_i,
`endif
    input  req_ready_o, pipe_valid_o, pipe_data_o, resp_valid_o, resp_data_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_data_i, flush_i, pipe_data_i,
`ifdef DELAY_PIPE_ARB_LOCK_EN
    input  req_lock_i,
`endif
    output req_ready_o, pipe_valid_o, pipe_data_o, resp_valid_o, resp_data_o, busy_o
  );
endinterface

// File: rtl/delay_pipe_arbiter.sv
// Round-robin arbiter feeding a shared fixed-latency pipe, with shadow tags routing results home.
// Optional DELAY_PIPE_ARB_LOCK_EN: a granted requester holding req_lock_i keeps priority.
module delay_pipe_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int LATENCY = 3
) (
  input logic clk,
  input logic rst,
  delay_pipe_arbiter_if.slave bus
);
  localparam int TAG_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  logic [TAG_W-1:0]   ptr_q, ptr_d;
  logic [LATENCY-1:0] sv_q;
  logic [TAG_W-1:0]   tag_q [LATENCY];
  logic               gnt;
  logic [TAG_W-1:0]   win;
  int                 idx;
`ifdef DELAY_PIPE_ARB_LOCK_EN
  logic               lock_q;
  logic [TAG_W-1:0]   lock_idx_q;
`endif

  always_comb begin
    gnt = 1'b0;
    win = '0;
    idx = 0;
    if (!rst && !bus.flush_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        // Explicit wrap: NUM_REQ need not be a power of two.
        idx = int'(ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!gnt && bus.req_valid_i[idx]) begin
          gnt = 1'b1;
          win = TAG_W'(idx);
        end
      end
`ifdef DELAY_PIPE_ARB_LOCK_EN
      if (lock_q && bus.req_valid_i[lock_idx_q]) begin
        gnt = 1'b1;
        win = lock_idx_q;
      end
`endif
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt) ptr_d = (win == TAG_W'(NUM_REQ-1)) ? '0 : win + TAG_W'(1);
`ifdef DELAY_PIPE_ARB_LOCK_EN
    if (gnt && bus.req_lock_i[win]) ptr_d = ptr_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      sv_q  <= '0;
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
`ifdef DELAY_PIPE_ARB_LOCK_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else if (bus.flush_i) begin
      sv_q <= '0;
`ifdef DELAY_PIPE_ARB_LOCK_EN
      lock_q <= 1'b0;
`endif
    end else begin
      ptr_q <= ptr_d;
      for (int i = LATENCY-1; i > 0; i--) begin
        sv_q[i]  <= sv_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
      sv_q[0]  <= gnt;
      tag_q[0] <= win;
`ifdef DELAY_PIPE_ARB_LOCK_EN
      lock_q     <= gnt && bus.req_lock_i[win];
      lock_idx_q <= win;
`endif
    end
  end

  assign bus.req_ready_o  = gnt ? (ONE_HOT0 << win) : '0;
  assign bus.pipe_valid_o = gnt;
  assign bus.pipe_data_o  = gnt ? bus.req_data_i[win*WIDTH +: WIDTH] : '0;
  // Reset is synchronous, so the shadow may still hold stale valids during the rst cycle.
  assign bus.resp_valid_o = (!rst && sv_q[LATENCY-1]) ? (ONE_HOT0 << tag_q[LATENCY-1]) : '0;
  assign bus.resp_data_o  = bus.pipe_data_i;
  assign bus.busy_o       = !rst && (|sv_q);
endmodule

// File: tb/tb_delay_pipe_arbiter.sv
// Directed bench for delay_pipe_arbiter with an external 3-stage pipe model.
// Test 6 expectations follow DELAY_PIPE_ARB_LOCK_EN.
module tb_delay_pipe_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  delay_pipe_arbiter_if #(.NUM_REQ(4), .WIDTH(4)) bus ();
  delay_pipe_arbiter #(.NUM_REQ(4), .WIDTH(4), .LATENCY(3)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [3:0] pq [3];
  always @(posedge clk) begin
    if (rst) begin
      pq[0] <= '0; pq[1] <= '0; pq[2] <= '0;
    end else begin
      pq[0] <= bus.pipe_data_o; pq[1] <= pq[0]; pq[2] <= pq[1];
    end
  end
  assign bus.pipe_data_i = pq[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic [3:0] e6 [4];

  initial begin
    rst = 1'b1;
    bus.req_valid_i = '0; bus.req_data_i = '0; bus.flush_i = 1'b0;
`ifdef DELAY_PIPE_ARB_LOCK_EN
    bus.req_lock_i = '0;
`endif
    // Test 1: reset then fairness
    tick(); #1;
    chk("rst1_ready", 32'(bus.req_ready_o), 0);
    chk("rst1_pvalid", 32'(bus.pipe_valid_o), 0);
    chk("rst1_busy", 32'(bus.busy_o), 0);
    tick();
    bus.req_valid_i = 4'b1111; bus.req_data_i = 16'h4321; #1;
    chk("rst2_ready", 32'(bus.req_ready_o), 0);
    chk("rst2_pdata", 32'(bus.pipe_data_o), 0);
    chk("rst2_resp", 32'(bus.resp_valid_o), 0);
    chk("rst2_rdata", 32'(bus.resp_data_o), 0);
    chk("rst2_busy", 32'(bus.busy_o), 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 8) bus.req_valid_i = '0;
      #1;
      chk("fair_ready", 32'(bus.req_ready_o), (c < 8) ? (32'd1 << (c % 4)) : 0);
      chk("fair_pdata", 32'(bus.pipe_data_o), (c < 8) ? 32'((c % 4) + 1) : 0);
      chk("fair_resp", 32'(bus.resp_valid_o), (c >= 3 && c <= 10) ? (32'd1 << ((c - 3) % 4)) : 0);
      chk("fair_rdata", 32'(bus.resp_data_o), (c >= 3 && c <= 10) ? 32'(((c - 3) % 4) + 1) : 0);
      chk("fair_busy", 32'(bus.busy_o), (c >= 1 && c <= 10) ? 1 : 0);
      tick();
    end

    // Test 2: single item from requester 2 (ptr=0)
    bus.req_valid_i = 4'b0100; bus.req_data_i = 16'h0A00; #1;
    chk("single_ready", 32'(bus.req_ready_o), 32'b0100);
    chk("single_pvalid", 32'(bus.pipe_valid_o), 1);
    chk("single_pdata", 32'(bus.pipe_data_o), 32'hA);
    chk("single_busy0", 32'(bus.busy_o), 0);
    tick();
    bus.req_valid_i = '0; #1;
    chk("single_busy1", 32'(bus.busy_o), 1);
    chk("single_pvalid1", 32'(bus.pipe_valid_o), 0);
    tick(); #1;
    chk("single_busy2", 32'(bus.busy_o), 1);
    chk("single_resp2", 32'(bus.resp_valid_o), 0);
    tick(); #1;
    chk("single_resp", 32'(bus.resp_valid_o), 32'b0100);
    chk("single_rdata", 32'(bus.resp_data_o), 32'hA);
    chk("single_busy3", 32'(bus.busy_o), 1);
    tick(); #1;
    chk("single_busy4", 32'(bus.busy_o), 0);
    chk("single_resp4", 32'(bus.resp_valid_o), 0);
    tick();

    // Test 3: wrap/skip (ptr=3 -> grant 0 -> ptr=1)
    bus.req_valid_i = 4'b0001; bus.req_data_i = 16'h5006; #1;
    chk("wrap_g0", 32'(bus.req_ready_o), 32'b0001);
    tick();
    bus.req_valid_i = 4'b1001; #1;
    chk("wrap_g3", 32'(bus.req_ready_o), 32'b1000);
    tick(); #1;
    chk("wrap_g0b", 32'(bus.req_ready_o), 32'b0001);
    tick();
    bus.req_valid_i = '0; #1;
    chk("wrap_r0", 32'(bus.resp_valid_o), 32'b0001);
    chk("wrap_d0", 32'(bus.resp_data_o), 32'h6);
    tick(); #1;
    chk("wrap_r3", 32'(bus.resp_valid_o), 32'b1000);
    chk("wrap_d3", 32'(bus.resp_data_o), 32'h5);
    tick(); #1;
    chk("wrap_r0b", 32'(bus.resp_valid_o), 32'b0001);
    tick();
    bus.req_valid_i = 4'b0011; #1;
    chk("wrap_ptr1", 32'(bus.req_ready_o), 32'b0010);
    chk("wrap_idle", 32'(bus.busy_o), 0);
    tick();
    bus.req_valid_i = '0;
    tick(); tick(); #1;
    chk("wrap_r1", 32'(bus.resp_valid_o), 32'b0010);
    tick(); #1;
    chk("wrap_busy", 32'(bus.busy_o), 0);
    tick();

    // Test 4: flush (ptr=2)
    bus.req_valid_i = 4'b0001; #1;
    chk("fl_g0", 32'(bus.req_ready_o), 32'b0001);
    tick();
    bus.req_valid_i = 4'b0010; #1;
    chk("fl_g1", 32'(bus.req_ready_o), 32'b0010);
    tick();
    bus.req_valid_i = 4'b1111; bus.flush_i = 1'b1; #1;
    chk("fl_ready", 32'(bus.req_ready_o), 0);
    chk("fl_pvalid", 32'(bus.pipe_valid_o), 0);
    chk("fl_pdata", 32'(bus.pipe_data_o), 0);
    chk("fl_busy", 32'(bus.busy_o), 1);
    tick();
    bus.flush_i = 1'b0; bus.req_valid_i = 4'b0100; #1;
    chk("fl_g2", 32'(bus.req_ready_o), 32'b0100);
    chk("fl_resp3", 32'(bus.resp_valid_o), 0);
    chk("fl_busy3", 32'(bus.busy_o), 0);
    tick();
    bus.req_valid_i = '0; #1;
    chk("fl_resp4", 32'(bus.resp_valid_o), 0);
    tick(); #1;
    chk("fl_resp5", 32'(bus.resp_valid_o), 0);
    chk("fl_busy5", 32'(bus.busy_o), 1);
    tick(); #1;
    chk("fl_resp6", 32'(bus.resp_valid_o), 32'b0100);
    tick(); #1;
    chk("fl_busy7", 32'(bus.busy_o), 0);
    tick();

    // Test 5: reset mid-operation (ptr=3 -> grants 3,0,1)
    bus.req_valid_i = 4'b1111; bus.req_data_i = 16'h4321; #1;
    chk("mr_g3", 32'(bus.req_ready_o), 32'b1000);
    tick(); tick(); #1;
    chk("mr_g1", 32'(bus.req_ready_o), 32'b0010);
    tick();
    rst = 1'b1; #1;
    chk("mr_ready", 32'(bus.req_ready_o), 0);
    chk("mr_resp", 32'(bus.resp_valid_o), 0);
    chk("mr_busy", 32'(bus.busy_o), 0);
    tick();
    rst = 1'b0; #1;
    chk("mr_g0", 32'(bus.req_ready_o), 32'b0001);
    chk("mr_resp1", 32'(bus.resp_valid_o), 0);
    tick();
    bus.req_valid_i = '0; #1;
    chk("mr_resp2", 32'(bus.resp_valid_o), 0);
    tick(); #1;
    chk("mr_resp3", 32'(bus.resp_valid_o), 0);
    tick(); #1;
    chk("mr_resp4", 32'(bus.resp_valid_o), 32'b0001);
    tick(); #1;
    chk("mr_busy5", 32'(bus.busy_o), 0);
    tick();

    // Test 6: lock (ptr=1)
`ifdef DELAY_PIPE_ARB_LOCK_EN
    e6[0] = 4'b0010; e6[1] = 4'b0010; e6[2] = 4'b0010; e6[3] = 4'b0100;
    bus.req_lock_i = 4'b0010;
`else
    e6[0] = 4'b0010; e6[1] = 4'b0100; e6[2] = 4'b1000; e6[3] = 4'b0001;
`endif
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        bus.req_valid_i = 4'b1101;
`ifdef DELAY_PIPE_ARB_LOCK_EN
        bus.req_lock_i = '0;
`endif
      end else begin
        bus.req_valid_i = 4'b1111;
      end
      #1;
      chk("lock_ready", 32'(bus.req_ready_o), 32'(e6[c]));
      tick();
    end
    bus.req_valid_i = '0;
    tick(); tick(); #1;
    chk("lock_resp", 32'(bus.resp_valid_o), 32'(e6[3]));
    tick(); #1;
    chk("lock_busy", 32'(bus.busy_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/delay_pipe_arbiter.md
Name: delay_pipe_arbiter

Overview:
Round-robin arbiter that shares one fixed-latency register pipeline (LATENCY stages, WIDTH bits, reset to zero) among NUM_REQ requesters. It grants at most one requester per cycle and drives the winner's data into the shared pipe. A shadow tag/valid shift register tracks each in-flight item and steers the pipe output back to its originator as a one-hot response. The block sits between the requesters and the shared delay datapath; the datapath itself stays outside this block.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 4, data width of the shared pipe
LATENCY, 3, register stages in the shared pipe (>=1); must equal the external pipe depth

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid_i  input  NUM_REQ  per-requester request valid
req_data_i  input  NUM_REQ*WIDTH  packed request data; requester i uses bits [i*WIDTH +: WIDTH]
req_ready_o  output  NUM_REQ  one-hot grant; zero or one bit set
flush_i  input  1  drop all in-flight items; block new grants this cycle
pipe_valid_o  output  1  an item enters the shared pipe this cycle
pipe_data_o  output  WIDTH  data to the shared pipe input
pipe_data_i  input  WIDTH  data from the shared pipe output
resp_valid_o  output  NUM_REQ  one-hot: the owner of pipe_data_i this cycle
resp_data_o  output  WIDTH  response data; pass-through of pipe_data_i
busy_o  output  1  at least one item is in flight

Behaviour:
- Reset (synchronous, rst high at the clock edge): round-robin pointer goes to 0 and all shadow valid/tag stages clear.
  - While rst is high: req_ready_o=0, pipe_valid_o=0, pipe_data_o=0, resp_valid_o=0, busy_o=0.
  - Reset mid-operation discards every in-flight item; no response is ever produced for it.
- Arbitration (combinational within cycle T):
  - Search requesters starting at ptr, increasing index, wrapping NUM_REQ-1 to 0.
  - The first requester with req_valid_i set wins and gets its req_ready_o bit.
  - req_ready_o depends on req_valid_i. A requester must not wait for ready before asserting valid.
  - Transfer to requester i happens when req_valid_i[i] and req_ready_o[i] are both high at the edge.
- Pointer update:
  - On a grant to requester i: ptr <= (i+1) mod NUM_REQ.
  - No grant: ptr holds.
  - Requester NUM_REQ-1 winning wraps ptr to 0.
- Pipe drive:
  - pipe_valid_o=1 and pipe_data_o=winner's data in the grant cycle.
  - With no grant: pipe_valid_o=0 and pipe_data_o=0. The pipe is free-running; zeros enter it.
- Shadow tracking:
  - LATENCY-stage shift register of {valid, tag[$clog2(NUM_REQ)-1:0]}; stage 0 loads {grant, winner index} every edge.
  - The item granted in cycle T reaches the last stage in cycle T+LATENCY, matching pipe_data_i.
  - resp_valid_o = last-stage valid ? onehot(last-stage tag) : 0.
  - resp_data_o = pipe_data_i, unregistered.
  - Response latency is exactly LATENCY cycles from grant.
- busy_o = OR of all shadow valid bits.
  - Goes high the cycle after a grant.
  - Drops the cycle after the last response cycle.
- Throughput: one grant per cycle, no bubbles. With continuous requests, one response per cycle.
- Flush (flush_i high in cycle T):
  - req_ready_o=0 and pipe_valid_o=0 in cycle T.
  - At the edge, all shadow valids clear and ptr holds.
  - Items granted before T never produce a response.
  - The grant in cycle T+1 proceeds normally.
- Simultaneous rst and flush_i: rst wins; the result is identical to reset.
- Widths: ptr and tags are $clog2(NUM_REQ) bits. Pointer wrap must be explicit, since NUM_REQ need not be a power of two.

Optional Feature:
Macro DELAY_PIPE_ARB_LOCK_EN.
- Defined:
  - Adds input req_lock_i [NUM_REQ].
  - If the requester granted in cycle T has req_lock_i set at the edge, it holds priority: in cycle T+1 it wins if valid, regardless of ptr.
  - ptr is not advanced while the lock is held.
  - The lock releases when lock or valid drops. The normal ptr update is applied on the final granted cycle.
  - flush_i and rst clear the lock.
- Undefined: the port is absent and arbitration is pure round-robin.

Test Plan:
1. Reset then fairness: rst high 2 cycles (all outputs 0, busy_o=0); then req_valid_i=4'b1111 continuously -> req_ready_o sequence 0001,0010,0100,1000,0001; resp_valid_o repeats that sequence starting 3 cycles later.
2. Single item: requester 2 only, data 4'hA, granted cycle T -> req_ready_o=4'b0100, pipe_data_o=4'hA in T; resp_valid_o=4'b0100, resp_data_o=4'hA in T+3; busy_o high T+1..T+3, low T+4.
3. Wrap/skip: ptr=1 (after a grant to 0), req_valid_i=4'b1001 -> grant 3 first, then 0; ptr ends at 1.
4. Flush: grants to 0 at T and 1 at T+1, flush_i at T+2 -> no resp_valid_o at T+3/T+4, busy_o=0 at T+3; grant to 2 at T+3 -> response at T+6.
5. Reset mid-operation: three grants in flight, rst pulsed one cycle -> no responses afterward, ptr=0, next all-valid request grants requester 0.
6. (DELAY_PIPE_ARB_LOCK_EN) requester 1 valid+lock 3 cycles, others valid -> grants 1,1,1, then 2; without the macro -> grants 1,2,3,0.
